// File: rtl/bus_datos_rtc.sv
// Data/address path for the RTC multiplexed AD bus.
// Holds the address and write-data registers loaded by PicoBlaze, drives them
// onto the bus under a turnaround FSM, and captures read data on LE rising.
module bus_datos_rtc #(
  parameter logic [7:0] ADDR_PORT   = 8'h02,
  parameter logic [7:0] DATA_PORT   = 8'h03,
  parameter logic [7:0] READ_PORT   = 8'h04,
  parameter logic [7:0] STATUS_PORT = 8'h05
) (
  input  logic       reloj,
  input  logic       resetM,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  input  logic       CS,
  input  logic       RD,
  input  logic       WR,
  input  logic       A_D,
  input  logic       LE,
  input  logic [7:0] dato_in,
  output logic [7:0] dato_out,
  output logic       dato_oe,
  output logic       dato_listo,
  output logic       error_bus
);

  typedef enum logic [2:0] {REPOSO, DIR, ESC, LEC, GIRO} estado_t;

  estado_t    state, state_nx;
  logic [7:0] dir_reg, wr_reg, rd_reg;
  logic       le_q;
  logic       captura, lee_dato, err_set, err_clr;
  logic [7:0] status;

  // RD and WR low together with CS low is a bus conflict, whatever the state
  assign err_set  = ~CS & ~RD & ~WR;
  assign err_clr  = write_strobe & (port_id == STATUS_PORT) & out_port[1];
  // only an LE rising edge while we are listening counts as read data
  assign captura  = (state == LEC) & LE & ~le_q;
  assign lee_dato = read_strobe & (port_id == READ_PORT);
  assign status   = {6'b0, error_bus, dato_listo};

  // state register
  always_ff @(posedge reloj) begin
    if (resetM) state <= REPOSO;
    else        state <= state_nx;
  end

  // next state: a direction change out of LEC, DIR or ESC goes through one
  // GIRO cycle so the block and the RTC never drive the bus together.
  // GIRO itself never matches the turnaround conditions, so it lasts one cycle.
  always_comb begin
    state_nx = state;
    if (CS)                state_nx = REPOSO;
    else if (~RD & ~WR)    state_nx = REPOSO;
    else if (~A_D & RD)    state_nx = (state == LEC) ? GIRO : DIR;
    else if (A_D & ~WR)    state_nx = (state == LEC) ? GIRO : ESC;
    else if (~RD)          state_nx = (state == DIR || state == ESC) ? GIRO : LEC;
    else if (state == GIRO) state_nx = REPOSO;
  end

  // bus drive decoded from the registered state only
  always_comb begin
    dato_oe  = 1'b0;
    dato_out = 8'h00;
    case (state)
      DIR:     begin dato_oe = 1'b1; dato_out = dir_reg; end
      ESC:     begin dato_oe = 1'b1; dato_out = wr_reg;  end
      default: begin dato_oe = 1'b0; dato_out = 8'h00;   end
    endcase
  end

  // PicoBlaze-loaded address and write-data registers
  always_ff @(posedge reloj) begin
    if (resetM) begin
      dir_reg <= 8'h00;
      wr_reg  <= 8'h00;
    end else if (write_strobe) begin
      if (port_id == ADDR_PORT) dir_reg <= out_port;
      if (port_id == DATA_PORT) wr_reg  <= out_port;
    end
  end

  // read capture; a capture beats a simultaneous READ_PORT read
  always_ff @(posedge reloj) begin
    if (resetM) begin
      le_q       <= 1'b0;
      rd_reg     <= 8'h00;
      dato_listo <= 1'b0;
    end else begin
      le_q <= LE;
      if (captura) begin
        rd_reg     <= dato_in;
        dato_listo <= 1'b1;
      end else if (lee_dato) begin
        dato_listo <= 1'b0;
      end
    end
  end

  // sticky conflict flag; a new conflict beats a simultaneous clear
  always_ff @(posedge reloj) begin
    if (resetM)       error_bus <= 1'b0;
    else if (err_set) error_bus <= 1'b1;
    else if (err_clr) error_bus <= 1'b0;
  end

  // registered read mux back to PicoBlaze
  always_ff @(posedge reloj) begin
    if (resetM)                      in_port <= 8'h00;
    else if (port_id == READ_PORT)   in_port <= rd_reg;
    else if (port_id == STATUS_PORT) in_port <= status;
    else                             in_port <= 8'h00;
  end

endmodule
